uart_frame_rx: RTL

//  Downstream of the uart RX FIFO: pops bytes via the rx_ready/rx/rx_data interface, parses

---
 rtl/uart_frame_rx.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// Frame parser behind the uart RX FIFO: [A5][LEN][payload][CHK], CHK = XOR of LEN and payload.
// Optional inter-byte timeout is compiled in with `define UART_FRAME_TIMEOUT_EN.
module uart_frame_rx #(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] drop_cnt
);
    typedef enum logic [1:0] {HUNT, LEN, DATA, CHK} state_t;

    localparam logic [8:0] MAX_L = 9'(MAX_LEN);

    state_t     state;
    logic       gap;
    logic [7:0] xr;
    logic [7:0] cnt;
    logic       can_take;
    logic       tmo;

    // Payload pops wait for a free (or draining) output register.
    assign can_take = (state != DATA) || !out_valid || out_ready;
    assign rx       = rx_ready && !gap && can_take;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] gap_cnt;
    logic          counting;

    assign counting = (state != HUNT) && !rx && !(state == DATA && out_valid && !out_ready);
    assign tmo      = counting && (gap_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        gap_cnt <= '0;
        else if (state == HUNT || rx || tmo) gap_cnt <= '0;
        else if (counting)               gap_cnt <= gap_cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            gap       <= 1'b0;
            xr        <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            drop_cnt  <= '0;
        end else begin
            gap       <= rx;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (rx) begin
                unique case (state)
                    HUNT: begin
                        if (rx_data == 8'hA5)       state    <= LEN;
                        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                    end
                    LEN: begin
                        if (rx_data == 8'd0 || {1'b0, rx_data} > MAX_L) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd1;
                            state     <= HUNT;
                        end else begin
                            xr    <= rx_data;
                            cnt   <= rx_data;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        out_data  <= rx_data;
                        out_valid <= 1'b1;
                        out_last  <= (cnt == 8'd1);
                        xr        <= xr ^ rx_data;
                        cnt       <= cnt - 8'd1;
                        if (cnt == 8'd1) state <= CHK;
                    end
                    CHK: begin
                        if (rx_data == xr) frame_ok <= 1'b1;
                        else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd2;
                        end
                        state <= HUNT;
                    end
                endcase
            end else if (tmo) begin
                // A payload byte already in the output register is still delivered.
                frame_err <= 1'b1;
                err_code  <= 2'd3;
                state     <= HUNT;
            end
        end
    end
endmodule
